// File: rtl/test_pattern_writer.sv
// test_pattern_writer
// Writes one IMG_W x IMG_H frame of test-pattern pixels ({8'h00, R, G, B}) into
// pixel memory in raster order. The patterns are colour bars, solid fill,
// checkerboard and horizontal gradient.
// Optional feature macro: PATGEN_CHECKSUM_EN adds a checksum output, which is
// the running mod-2**32 sum of every retired write in the current frame.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_WRITE | presenting pixel (x,y); it retires on mem_ack
// S_DONE  | frame complete, done held high; a new start is accepted
module test_pattern_writer #(
  parameter int          ADDR_W     = 18,
  parameter int          IMG_W      = 32,
  parameter int          IMG_H      = 32,
  parameter logic [23:0] FILL_COLOR = 24'hFFFFFF,
  parameter int          CHECK_LOG2 = 2,
  parameter int          GRAD_STEP  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pause,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] starting_address,
  input  logic              mem_ack,
`ifdef PATGEN_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic [31:0]       data_write,
  output logic [ADDR_W-1:0] addr,
  output logic              wren,
  output logic              busy,
  output logic              done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned BAND_W  = IMG_W / 8;
  localparam int unsigned SUB_W   = BAND_W / 4;
  localparam int unsigned ROW_MID = IMG_H / 2;
  localparam int unsigned ROW_BOT = (3 * IMG_H) / 4;
  localparam int unsigned GSTEP   = GRAD_STEP;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        pix_mode;
  logic [XW-1:0]     pix_x;
  logic [YW-1:0]     pix_y;
  logic              load_pixel;
  logic              last_pixel;
`ifdef PATGEN_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
`endif

  // Colour of pixel (px,py) under pattern m.
  function automatic logic [23:0] pattern_color(input logic [1:0] m,
                                                input logic [XW-1:0] px,
                                                input logic [YW-1:0] py);
    logic [23:0] c;
    logic [2:0]  band;
    logic [1:0]  quarter;
    logic [7:0]  level;
    int unsigned xi;
    int unsigned yi;
    xi      = 32'(px);
    yi      = 32'(py);
    band    = 3'(xi / BAND_W);
    quarter = 2'((xi % BAND_W) / SUB_W);
    level   = 8'(xi * GSTEP);
    c       = 24'h000000;
    case (m)
      2'd0: begin
        if (yi < ROW_MID) begin
          case (band)
            3'd0: c = 24'hC0C0C0;
            3'd1: c = 24'hC0C000;
            3'd2: c = 24'h00C0C0;
            3'd3: c = 24'h00C000;
            3'd4: c = 24'hC000C0;
            3'd5: c = 24'hC00000;
            3'd6: c = 24'h0000C0;
            default: c = 24'hFFFFFF;
          endcase
        end else if (yi < ROW_BOT) begin
          case (band)
            3'd0: c = 24'h0000C0;
            3'd2: c = 24'hC000C0;
            3'd4: c = 24'h00C0C0;
            3'd6: c = 24'hC0C0C0;
            default: c = 24'h131313;
          endcase
        end else begin
          case (band)
            3'd0: c = 24'h00214C;
            3'd1: c = 24'hFFFFFF;
            3'd2: c = 24'h32006A;
            3'd4: begin
              // PLUGE-style band: black, reference, slightly brighter, black
              case (quarter)
                2'd0: c = 24'h090909;
                2'd1: c = 24'h131313;
                2'd2: c = 24'h1D1D1D;
                default: c = 24'h090909;
              endcase
            end
            3'd6: c = 24'hC0C0C0;
            default: c = 24'h131313;
          endcase
        end
      end
      2'd1: c = FILL_COLOR;
      2'd2: c = (px[CHECK_LOG2] ^ py[CHECK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
      default: c = {level, level, level};
    endcase
    return c;
  endfunction

  assign last_pixel = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));

  // Next-state, pixel advance and output register loading; pause holds everything.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wren_d     = wren_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pix_mode   = mode_q;
    pix_x      = x_q;
    pix_y      = y_q;
    load_pixel = 1'b0;
`ifdef PATGEN_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    if (!pause) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d    = S_WRITE;
            x_d        = '0;
            y_d        = '0;
            mode_d     = mode;
            pix_mode   = mode;
            pix_x      = '0;
            pix_y      = '0;
            load_pixel = 1'b1;
            addr_d     = starting_address;
            wren_d     = 1'b1;
            busy_d     = 1'b1;
            done_d     = 1'b0;
`ifdef PATGEN_CHECKSUM_EN
            sum_d      = '0;
`endif
          end
        end
        S_WRITE: begin
          if (wren_q && mem_ack) begin
`ifdef PATGEN_CHECKSUM_EN
            sum_d = sum_q + data_q;
`endif
            if (last_pixel) begin
              state_d = S_DONE;
              wren_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              if (x_q == XW'(IMG_W - 1)) begin
                x_d = '0;
                y_d = y_q + YW'(1);
              end else begin
                x_d = x_q + XW'(1);
              end
              // raster order makes the next address simply the next word
              addr_d     = addr_q + ADDR_W'(1);
              pix_x      = x_d;
              pix_y      = y_d;
              load_pixel = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          wren_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
    if (load_pixel) begin
      data_d = {8'h00, pattern_color(pix_mode, pix_x, pix_y)};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= 2'd0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PATGEN_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PATGEN_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // pause suppresses the request without touching the held pixel
  assign wren       = wren_q & ~pause;
  assign addr       = addr_q;
  assign data_write = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef PATGEN_CHECKSUM_EN
  assign checksum   = sum_q;
`endif

endmodule
